// File: rtl/tc_b_dn_ctrl_pkg.sv
// Shared types and constants for the B-operand distribution network sequencer.
package tc_pkg;

  localparam int NUM_TILE = 16;
  localparam int DW_DATA  = 16;
  localparam int N_PE     = 4;
  localparam int AW       = 10;
  localparam int CNT_W    = 8;

  localparam int TILE_W = NUM_TILE * DW_DATA;
  localparam logic [N_PE-1:0] ALL_ACK = {N_PE{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    BCAST,
    DONE
  } state_e;

endpackage

// File: rtl/tc_b_dn_ctrl_if.sv
// B buffer read port plus distribution network / PE handshake bundle.
interface tc_b_dn_ctrl_if;
  import tc_pkg::*;

  logic              rd_req;
  logic [AW-1:0]     rd_addr;
  logic              rd_valid;
  logic [TILE_W-1:0] rd_data;
  logic [TILE_W-1:0] dn_in_b;
  logic [N_PE-1:0]   pe_valid;
  logic [N_PE-1:0]   pe_ready;

  modport master (
    output rd_req, rd_addr, dn_in_b, pe_valid,
    input  rd_valid, rd_data, pe_ready
  );

  modport slave (
    input  rd_req, rd_addr, dn_in_b, pe_valid,
    output rd_valid, rd_data, pe_ready
  );

endinterface

// File: rtl/tc_b_dn_ctrl_ack_tracker.sv
// Sticky per-PE accept mask for the tile currently being broadcast.
module tc_bdn_ack_tracker
  import tc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic [N_PE-1:0] pe_valid,
  input  logic [N_PE-1:0] pe_ready,
  output logic [N_PE-1:0] acked,
  output logic            all_acked
);

  logic [N_PE-1:0] acked_q;
  logic [N_PE-1:0] acked_d;
  logic [N_PE-1:0] hs;

  always_comb begin
    hs      = pe_valid & pe_ready;
    acked_d = clear ? '0 : (acked_q | hs);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acked_q <= '0;
    end else begin
      acked_q <= acked_d;
    end
  end

  assign acked = acked_q;
  // Completion looks through this cycle's handshakes so the FSM can advance on that edge.
  assign all_acked = ((acked_q | hs) == ALL_ACK);

endmodule

// File: rtl/tc_b_dn_ctrl.sv
// B-tile fetch / hold / broadcast sequencer. Define TC_BDN_CTRL_PERF_EN to build
// the stall_cycles performance counter; otherwise the port reads constant zero.
module tc_b_dn_ctrl
  import tc_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_tiles,
  input  logic [AW-1:0]         base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           stall_cycles,
  tc_b_dn_ctrl_if.master        bif
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  tile_idx_q, tile_idx_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic [TILE_W-1:0] dn_in_b_q, dn_in_b_d;
  logic              rd_req_q, rd_req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [N_PE-1:0]   acked;
  logic [N_PE-1:0]   pe_valid;
  logic              all_acked;

  assign pe_valid = (state_q == BCAST) ? ~acked : '0;

  tc_bdn_ack_tracker u_ack_tracker (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_q != BCAST),
    .pe_valid  (pe_valid),
    .pe_ready  (bif.pe_ready),
    .acked     (acked),
    .all_acked (all_acked)
  );

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    tile_idx_d = tile_idx_q;
    rd_addr_d  = rd_addr_q;
    dn_in_b_d  = dn_in_b_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_d      = num_tiles;
          tile_idx_d = '0;
          rd_addr_d  = base_addr;
          state_d    = (num_tiles == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (bif.rd_valid) begin
          dn_in_b_d = bif.rd_data;
          state_d   = LOAD;
        end
      end
      LOAD: state_d = BCAST;
      BCAST: begin
        if (all_acked) begin
          if (tile_idx_q == num_q - CNT_W'(1)) begin
            state_d = DONE;
          end else begin
            tile_idx_d = tile_idx_q + CNT_W'(1);
            rd_addr_d  = rd_addr_q + AW'(1);
            state_d    = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status outputs are registered off the next state so they line up with it.
    rd_req_d = (state_d == FETCH);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      num_q      <= '0;
      tile_idx_q <= '0;
      rd_addr_q  <= '0;
      dn_in_b_q  <= '0;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      tile_idx_q <= tile_idx_d;
      rd_addr_q  <= rd_addr_d;
      dn_in_b_q  <= dn_in_b_d;
      rd_req_q   <= rd_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bif.rd_req   = rd_req_q;
  assign bif.rd_addr  = rd_addr_q;
  assign bif.dn_in_b  = dn_in_b_q;
  assign bif.pe_valid = pe_valid;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef TC_BDN_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Counts cycles spent waiting on the buffer or on slow PEs; saturating.
  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = '0;
    end else if (((state_q == FETCH && !bif.rd_valid) ||
                  (state_q == BCAST && !all_acked)) && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/tc_b_dn_ctrl.md
# tc_b_dn_ctrl

Sequencer for the B-operand distribution network of the sparse tensor core. It fetches a job's B tiles one at a time from the B buffer and holds each tile on the distribution network input. Once the network's one-cycle register stage has settled, it broadcasts the tile to all N_PE processing elements and waits until every PE has accepted it before advancing. It sits between the B buffer read port and the distribution network plus PE array.

## Interface
- NUM_TILE, 16, elements per B tile (4x4)
- DW_DATA, 16, element width in bits
- N_PE, 4, number of PEs fed by the network
- AW, 10, B buffer address width
- CNT_W, 8, tile-count width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  job start; accepted only in IDLE
- num_tiles  in  CNT_W  tiles in job; sampled on accepted start
- base_addr  in  AW  first tile address; sampled on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- rd_req  out  1  B buffer read request
- rd_addr  out  AW  tile address
- rd_valid  in  1  read data valid
- rd_data  in  NUM_TILE*DW_DATA  tile data
- dn_in_b  out  NUM_TILE*DW_DATA  registered, held network input
- pe_valid  out  N_PE  per-PE tile-available flags
- pe_ready  in  N_PE  per-PE accept
- stall_cycles  out  32  performance counter

## Operation
- States: IDLE, FETCH, LOAD, BCAST, DONE.
- IDLE
  - start=1 latches num_tiles, base_addr, tile_idx=0 and rd_addr=base_addr.
  - Next state is FETCH, or DONE if num_tiles=0. A zero-tile job issues no reads.
- FETCH
  - rd_req=1 and is held until rd_valid=1.
  - On rd_valid=1: dn_in_b<=rd_data, go to LOAD.
  - rd_valid in any other state is ignored.
- LOAD: one cycle, during which the network registers dn_in_b. dn_in_b is stable.
- BCAST
  - pe_valid = ~acked. acked is a per-PE sticky mask, cleared on BCAST entry.
  - PE i handshake: pe_valid[i] & pe_ready[i] sets acked[i].
  - When (acked | handshake) is all ones: if tile_idx==num_tiles-1 go to DONE. Otherwise tile_idx++, rd_addr++, go to FETCH.
  - A PE that has acked is not offered the tile again.
- DONE: done=1 for one cycle, then IDLE.
- start while busy is ignored; num_tiles and base_addr are not resampled.
- rd_addr wraps modulo 2^AW.
- dn_in_b changes only on a FETCH-state rd_valid, so the network output never changes while pe_valid!=0.
- Reset (async, any state) sets all state and outputs to 0: state IDLE, busy 0, done 0, rd_req 0, rd_addr 0, dn_in_b 0, pe_valid 0, stall_cycles 0, acked 0. An in-flight tile is discarded.

## Timing
- Accepted start at edge E0: rd_req=1 from E0.
- rd_valid sampled at edge E: LOAD in cycle E..E+1, pe_valid=all ones from E+1.
- Minimum per-tile period is 3 cycles (FETCH, LOAD, BCAST), assuming rd_valid and all pe_ready are high the first cycle.
- done rises the cycle after the final all-ack edge.
- All outputs are registered or decoded from state/acked only. pe_ready→pe_valid is not a combinational path within a cycle.

## Configuration
- TC_BDN_CTRL_PERF_EN defined:
  - stall_cycles counts FETCH cycles with rd_valid=0, plus BCAST cycles where the tile is not fully acked at the clock edge.
  - Cleared on accepted start; saturates at 2^32-1.
- Not defined: stall_cycles is tied to 0 and no counter logic exists. The port is present in both builds.

## Structure
- Shared package tc_pkg holds:
  - the state enum (IDLE, FETCH, LOAD, BCAST, DONE)
  - the tile bit-width localparam NUM_TILE*DW_DATA
  - the all-ack constant {N_PE{1'b1}}
- One sub-module, tc_bdn_ack_tracker: the sticky N_PE acked mask.
  - Inputs: clear, pe_valid, pe_ready.
  - Outputs: acked and all_acked, where all_acked includes the current-cycle handshakes.

## Test plan
- Reset: assert reset=0 mid-BCAST of tile 2 → all outputs 0 immediately. After release, the next start=1 fetches from the newly given base_addr.
- Single tile: num_tiles=1, base_addr=0x010, rd_valid 2 cycles after rd_req, pe_ready=4'hF → rd_addr=0x010, one LOAD cycle, pe_valid=4'hF for exactly one cycle, done pulse one cycle later.
- Staggered accept: num_tiles=1, pe_ready bits rise at cycles +0,+2,+2,+5 of BCAST → pe_valid 4'hF→4'hE→4'h8→0. Done after the fifth cycle. dn_in_b is stable throughout.
- Multi-tile with wrap: num_tiles=3, base_addr=0x3FF (AW=10) → addresses 0x3FF, 0x000, 0x001. tile_idx ends at 2, exactly one done pulse.
- Zero tiles and busy start: num_tiles=0 → done one cycle after start, rd_req never asserted. A start pulse during BCAST of a 2-tile job has no effect.
- Perf (TC_BDN_CTRL_PERF_EN): 1 tile, rd_valid delayed 3 cycles, one PE late by 2 cycles → stall_cycles=5. Without the macro, stall_cycles reads 0.
